// File: rtl/data_producer.sv
// AXI4-Stream packet source: emits packet_count packets of packet_size bytes with
// a deterministic byte pattern, trimming the final beat of each packet with TKEEP.
module data_producer #(
  parameter int DW = 512
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [15:0]       packet_count,
  input  logic [15:0]       packet_size,
  output logic [DW-1:0]     AXIS_TX_TDATA,
  output logic [DW/8-1:0]   AXIS_TX_TKEEP,
  output logic              AXIS_TX_TLAST,
  output logic              AXIS_TX_TVALID,
  input  logic              AXIS_TX_TREADY,
  output logic              busy,
  output logic              done
);

  localparam int BPB = DW / 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_nxt;
  logic [15:0] cfg_count, cfg_size;
  logic [15:0] pkt_idx, beat_idx, byte_off;
  logic [15:0] nxt_pkt, nxt_beat, nxt_off;
  logic [15:0] cfg_nb, cfg_rem, in_nb, in_rem, nb_sel, rem_sel;
  logic        busy_nxt, done_nxt, accept, load, finish, handshake;
  logic        nxt_last;
  logic [BPB-1:0] nxt_keep;
  logic [DW-1:0]  nxt_data;

  function automatic logic [15:0] beats_of(input logic [15:0] size);
    logic [15:0] q, r;
    q = size / 16'(BPB);
    r = size % 16'(BPB);
    return q + ((r != 16'd0) ? 16'd1 : 16'd0);
  endfunction

  function automatic logic [BPB-1:0] keep_of(input logic last, input logic [15:0] rem);
    logic [BPB-1:0] keep;
    for (int k = 0; k < BPB; k++)
      keep[k] = !last || (rem == 16'd0) || (16'(k) < rem);
    return keep;
  endfunction

  // Only the low byte of pkt + offset + lane survives the mod-256 pattern.
  function automatic logic [DW-1:0] data_of(input logic [7:0] pkt, input logic [7:0] off,
                                            input logic [BPB-1:0] keep);
    logic [DW-1:0] data;
    logic [7:0]    lane;
    data = '0;
    for (int k = 0; k < BPB; k++) begin
      lane = pkt + off + 8'(k);
      data[8*k +: 8] = keep[k] ? lane : 8'h00;
    end
    return data;
  endfunction

  assign cfg_nb    = beats_of(cfg_size);
  assign cfg_rem   = cfg_size % 16'(BPB);
  assign in_nb     = beats_of(packet_size);
  assign in_rem    = packet_size % 16'(BPB);
  assign handshake = AXIS_TX_TVALID && AXIS_TX_TREADY;

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    nxt_pkt   = pkt_idx;
    nxt_beat  = beat_idx;
    nxt_off   = byte_off;
    nb_sel    = cfg_nb;
    rem_sel   = cfg_rem;
    case (state)
      IDLE: begin
        if (start) begin
          if (packet_count != 16'd0 && packet_size != 16'd0) begin
            accept    = 1'b1;
            load      = 1'b1;
            nxt_pkt   = 16'd0;
            nxt_beat  = 16'd0;
            nxt_off   = 16'd0;
            nb_sel    = in_nb;
            rem_sel   = in_rem;
            state_nxt = SEND;
            busy_nxt  = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        if (handshake) begin
          if (beat_idx == cfg_nb - 16'd1) begin
            if (pkt_idx == cfg_count - 16'd1) begin
              finish    = 1'b1;
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              load     = 1'b1;
              nxt_pkt  = pkt_idx + 16'd1;
              nxt_beat = 16'd0;
              nxt_off  = 16'd0;
            end
          end else begin
            load     = 1'b1;
            nxt_beat = beat_idx + 16'd1;
            nxt_off  = byte_off + 16'(BPB);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign nxt_last = (nxt_beat == nb_sel - 16'd1);
  assign nxt_keep = keep_of(nxt_last, rem_sel);
  assign nxt_data = data_of(nxt_pkt[7:0], nxt_off[7:0], nxt_keep);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      cfg_count      <= '0;
      cfg_size       <= '0;
      pkt_idx        <= '0;
      beat_idx       <= '0;
      byte_off       <= '0;
      AXIS_TX_TVALID <= 1'b0;
      AXIS_TX_TLAST  <= 1'b0;
      AXIS_TX_TDATA  <= '0;
      AXIS_TX_TKEEP  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      if (accept) begin
        cfg_count <= packet_count;
        cfg_size  <= packet_size;
      end
      // Output beat register: loads on accept or handshake, holds during stalls.
      if (load) begin
        pkt_idx        <= nxt_pkt;
        beat_idx       <= nxt_beat;
        byte_off       <= nxt_off;
        AXIS_TX_TVALID <= 1'b1;
        AXIS_TX_TLAST  <= nxt_last;
        AXIS_TX_TKEEP  <= nxt_keep;
        AXIS_TX_TDATA  <= nxt_data;
      end else if (finish) begin
        AXIS_TX_TVALID <= 1'b0;
        AXIS_TX_TLAST  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_producer.sv
// Scoreboard bench for data_producer: a byte-index model fills the expected queue
// at start, observed handshakes fill a second queue that each test compares.
module tb_data_producer;

  localparam int DW  = 512;
  localparam int BPB = DW / 8;

  logic           clk = 1'b0;
  logic           resetn;
  logic           start;
  logic [15:0]    packet_count, packet_size;
  logic [DW-1:0]  tdata;
  logic [BPB-1:0] tkeep;
  logic           tlast, tvalid, tready;
  logic           busy, done;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [BPB-1:0] keep;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t obs_arr[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    stall_bad;

  always #5 clk = ~clk;

  data_producer #(.DW(DW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .packet_count(packet_count), .packet_size(packet_size),
    .AXIS_TX_TDATA(tdata), .AXIS_TX_TKEEP(tkeep), .AXIS_TX_TLAST(tlast),
    .AXIS_TX_TVALID(tvalid), .AXIS_TX_TREADY(tready),
    .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: byte i of packet p is (p + i) mod 256; bytes past the packet end are 0 / keep 0.
  task automatic push_run(input int cnt, input int sz);
    int nb;
    beat_t e;
    nb = (sz + BPB - 1) / BPB;
    for (int p = 0; p < cnt; p++)
      for (int b = 0; b < nb; b++) begin
        e.data = '0;
        e.keep = '0;
        for (int k = 0; k < BPB; k++)
          if (b * BPB + k < sz) begin
            e.keep[k] = 1'b1;
            e.data[8*k +: 8] = 8'((p + b * BPB + k) % 256);
          end
        e.last = (b == nb - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic pulse_start(input int cnt, input int sz);
    packet_count = 16'(cnt);
    packet_size  = 16'(sz);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Collects n handshakes into obs_q (bounded); records any output change during a stall.
  task automatic drain(input int n, input bit rnd, output int got);
    beat_t snap;
    logic  snap_v;
    bit    held;
    int    cycles;
    got = 0;
    cycles = 0;
    stall_bad = 0;
    while (got < n && cycles < 2000) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 1'b0;
      if (tvalid && tready) begin
        obs_q.push_back('{tdata, tkeep, tlast});
        got++;
      end else if (tvalid) begin
        held = 1'b1;
        snap = '{tdata, tkeep, tlast};
        snap_v = tvalid;
      end
      step();
      if (held && (snap !== beat_t'{tdata, tkeep, tlast} || snap_v !== tvalid))
        stall_bad++;
      cycles++;
    end
    tready = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start = 1'b0;
    tready = 1'b0;
    packet_count = '0;
    packet_size = '0;
    repeat (3) step();
    n_cmp++;
    if ({tvalid, tlast, busy, done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl got vld/last/busy/done=%b want 0000", {tvalid, tlast, busy, done});
    end
    n_cmp++;
    if (tdata !== '0 || tkeep !== '0) begin
      n_bad++;
      $display("FAIL reset_data got keep=%h want 0", tkeep);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int got;
    push_run(2, 128);
    pulse_start(2, 128);
    n_cmp++;
    if (tvalid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_first got vld=%b busy=%b want 1 1", tvalid, busy);
    end
    drain(4, 1'b0, got);
    n_cmp++;
    if (got !== 4) begin n_bad++; $display("FAIL basic_count got %0d want 4", got); end
    n_cmp++;
    if ({done, busy, tvalid} !== 3'b100) begin
      n_bad++;
      $display("FAIL basic_done got done/busy/vld=%b want 100", {done, busy, tvalid});
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
    obs_arr = obs_q;
    n_cmp++;
    if (obs_arr.size() != 4 || obs_arr[0].data[7:0] !== 8'h00 || obs_arr[2].data[7:0] !== 8'h01) begin
      n_bad++;
      $display("FAIL basic_byte0 got size=%0d", obs_arr.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL basic_beat got keep=%h last=%b want keep=%h last=%b", o.keep, o.last, e.keep, e.last);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL basic_left got exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_partial();
    int got;
    logic [BPB-1:0] want_keep;
    want_keep = 64'h0000000FFFFFFFFF;
    push_run(1, 100);
    pulse_start(1, 100);
    drain(2, 1'b0, got);
    obs_arr = obs_q;
    n_cmp++;
    if (got !== 2 || obs_arr[1].keep !== want_keep || obs_arr[1].last !== 1'b1) begin
      n_bad++;
      $display("FAIL partial_keep got n=%0d keep=%h want 2 keep=%h", got, obs_arr[1].keep, want_keep);
    end
    n_cmp++;
    if (obs_arr[1].data[7:0] !== 8'h40 || obs_arr[1].data[8*35 +: 8] !== 8'h63 ||
        obs_arr[1].data[DW-1:8*36] !== '0) begin
      n_bad++;
      $display("FAIL partial_lanes got lane0=%h lane35=%h", obs_arr[1].data[7:0], obs_arr[1].data[8*35 +: 8]);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL partial_beat got keep=%h last=%b want keep=%h last=%b", o.keep, o.last, e.keep, e.last);
      end
    end
    exp_q.delete();
    obs_q.delete();
    step();
  endtask

  task automatic test_random_ready();
    int got, lasts;
    push_run(3, 200);
    pulse_start(3, 200);
    drain(12, 1'b1, got);
    n_cmp++;
    if (got !== 12) begin n_bad++; $display("FAIL rnd_count got %0d want 12", got); end
    n_cmp++;
    if (stall_bad !== 0) begin n_bad++; $display("FAIL rnd_stall got %0d changes want 0", stall_bad); end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rnd_done got done=%b busy=%b want 1 0", done, busy);
    end
    lasts = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o.last) lasts++;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rnd_beat got keep=%h last=%b want keep=%h last=%b", o.keep, o.last, e.keep, e.last);
      end
    end
    n_cmp++;
    if (lasts !== 3) begin n_bad++; $display("FAIL rnd_tlast got %0d want 3", lasts); end
    exp_q.delete();
    obs_q.delete();
    step();
  endtask

  task automatic test_zero_cfg();
    int seen;
    pulse_start(0, 64);
    n_cmp++;
    if ({done, busy, tvalid} !== 3'b100) begin
      n_bad++;
      $display("FAIL zero_count got done/busy/vld=%b want 100", {done, busy, tvalid});
    end
    pulse_start(3, 0);
    n_cmp++;
    if ({done, busy, tvalid} !== 3'b100) begin
      n_bad++;
      $display("FAIL zero_size got done/busy/vld=%b want 100", {done, busy, tvalid});
    end
    seen = 0;
    repeat (5) begin
      step();
      if (tvalid || busy || done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL zero_quiet got %0d active cycles want 0", seen); end
  endtask

  task automatic test_restart_ignored();
    int got, seen;
    push_run(2, 128);
    pulse_start(2, 128);
    tready = 1'b0;
    step();
    packet_size = 16'd64;
    packet_count = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    drain(3, 1'b0, got);
    start = 1'b1;
    step();
    start = 1'b0;
    obs_q.push_back('{tdata, tkeep, tlast});
    n_cmp++;
    if (got !== 3 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_end got n=%0d done=%b want 3 1", got, done);
    end
    seen = 0;
    repeat (10) begin
      step();
      if (tvalid || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL restart_second_run got %0d busy cycles want 0", seen); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o.data !== e.data || o.keep !== e.keep) begin
        n_bad++;
        $display("FAIL restart_beat got keep=%h byte0=%h want keep=%h byte0=%h", o.keep, o.data[7:0], e.keep, e.data[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_midrun();
    int got;
    tready = 1'b1;
    pulse_start(1, 256);
    step();
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({tvalid, tlast, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset_async got vld/last/busy=%b want 000", {tvalid, tlast, busy});
    end
    step();
    resetn = 1'b1;
    step();
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_resume got vld=%b busy=%b want 0 0", tvalid, busy);
    end
    push_run(1, 64);
    pulse_start(1, 64);
    drain(1, 1'b0, got);
    n_cmp++;
    if (got !== 1 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_single got n=%0d done=%b want 1 1", got, done);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL midreset_beat got byte1=%h last=%b want byte1=%h last=%b", o.data[15:8], o.last, e.data[15:8], e.last);
      end
    end
    exp_q.delete();
    obs_q.delete();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_random_ready();
    test_zero_cfg();
    test_restart_ignored();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_producer.md
Name: data_producer

Overview:
AXI4-Stream packet source that drives the transmit side of the stream link. Its output feeds a stream sink such as data_consumer. On a start pulse it latches packet_count and packet_size and emits that many packets of that many bytes each. Payload is a deterministic byte pattern so the receive end can check it. TKEEP trims the final beat of each packet, and the block reports busy/done status.

Parameters:
DW, 512, stream data width in bits; a multiple of 8 and at least 8; bytes per beat BPB = DW/8

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a run; ignored while busy=1
packet_count  input  16  number of packets per run; sampled on accepted start
packet_size  input  16  bytes per packet; sampled on accepted start
AXIS_TX_TDATA  output  DW  stream data, registered
AXIS_TX_TKEEP  output  DW/8  byte enables, registered
AXIS_TX_TLAST  output  1  last beat of a packet, registered
AXIS_TX_TVALID  output  1  beat valid, registered
AXIS_TX_TREADY  input  1  downstream ready
busy  output  1  high from accepted start until the run completes
done  output  1  one-cycle pulse at run completion

Behaviour:
- Reset (resetn low, asynchronous): TVALID=0, TLAST=0, TDATA=0, TKEEP=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-packet abandons the packet immediately; no resume after release.
- Registers: cfg_count and cfg_size latch on accepted start. Later changes on the inputs have no effect until the next run.
- Counters: pkt_idx (16 b), beat_idx (16 b), byte_off (16 b, = beat_idx*BPB). Beats per packet NB = ceil(cfg_size/BPB).
- State machine IDLE -> SEND -> IDLE:
  - IDLE, start=1 with cfg values both non-zero: latch config, busy=1, load beat 0 of packet 0 with TVALID=1 on the next edge. First TVALID is high 1 cycle after start.
  - IDLE, start=1 with packet_count==0 or packet_size==0: no beats emitted. done=1 and busy=0 on the next cycle; busy is never seen high.
  - SEND: a handshake is TVALID & TREADY.
    - On a handshake, the next beat loads in the same edge, so TREADY held high gives 1 beat/cycle with no bubbles.
    - After the handshake of the last beat of the last packet: TVALID=0, state=IDLE, busy=0, and done=1 for exactly one cycle, all on the same edge.
  - While TVALID=1 and TREADY=0: TDATA, TKEEP, TLAST and TVALID hold unchanged.
  - TVALID never deasserts without a handshake, except on reset.
- Beat content:
  - Byte lane k of beat b in packet p = (p + b*BPB + k) mod 256, computed with 16-bit truncated arithmetic.
  - Lanes with TKEEP=0 carry 0x00.
  - TKEEP is all ones on non-final beats. On the final beat, rem = cfg_size mod BPB: rem==0 gives all ones, otherwise only the low rem bits are set.
  - TLAST=1 only on beat NB-1 of each packet.
- Packets follow back-to-back with no idle cycle between them; pkt_idx increments on each TLAST handshake.
- A start pulse while busy=1 is ignored and does not queue. A start on the same cycle as the final handshake is also ignored; the next run needs start after busy falls.
- The internal beat counter supports packet_size=65535 with DW=8, i.e. NB up to 65535.

Test Plan:
- DW=512, count=2, size=128, TREADY=1 -> 4 consecutive beats, TKEEP all ones, TLAST on beats 2 and 4. Beat 1 byte 0=0x00; packet 1 beat 1 byte 0=0x01. done pulses the cycle after beat 4; busy high cycles 1-4.
- count=1, size=100 -> 2 beats. Beat 2 TKEEP=0x0000000FFFFFFFFF; lanes 0-35 hold 0x40..0x63; lanes 36-63 hold 0x00; TLAST=1.
- count=3, size=200, TREADY random at 50% -> 12 handshakes, TLAST on handshakes 4, 8 and 12. Outputs bit-stable during every stall; scoreboard matches the byte pattern.
- size=0 (or count=0), start -> TVALID never rises; done=1 one cycle after start; busy stays 0.
- start pulsed again mid-run, and packet_size changed mid-run -> run completes with the original config; no second run.
- resetn low during beat 2 of 4 -> TVALID/TLAST/busy drop to 0 asynchronously. After release with count=1, size=64 and start -> single beat, pkt_idx 0 pattern (byte k = k), TLAST=1.
